// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth product accumulator.
// PROD_W/OP_W describe the upstream 8x8 Booth multiplier interface.
package booth_pkg;

  localparam int PROD_W = 16;
  localparam int OP_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/booth_acc_add.sv
// Combinational accumulate step: sign-extend p, add, flag signed overflow.
// Ports: acc_i, p_i in; sum_o, ovf_o out. BOOTH_ACC_SAT_EN clamps on ovf.
module booth_acc_add
  import booth_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] p_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W:0] acc_x;
  logic [ACC_W:0] p_x;
  logic [ACC_W:0] sum_x;

  assign acc_x = {acc_i[ACC_W-1], acc_i};
  assign p_x   = {{(ACC_W+1-PROD_W){p_i[PROD_W-1]}}, p_i};
  assign sum_x = acc_x + p_x;

  // The two top bits disagree exactly when operand signs match
  // and the ACC_W-bit result sign flipped.
  assign ovf_o = sum_x[ACC_W] ^ sum_x[ACC_W-1];

`ifdef BOOTH_ACC_SAT_EN
  always_comb begin
    sum_o = sum_x[ACC_W-1:0];
    if (ovf_o) begin
      if (p_i[PROD_W-1])
        sum_o = {1'b1, {(ACC_W-1){1'b0}}};
      else
        sum_o = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum_o = sum_x[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_acc.sv
// Dot-product accumulator behind a Booth multiplier, valid/ready result port.
// Ports: start/len job setup, p/p_valid/p_ready in, acc_out/out_valid/out_ready.
module booth_acc
  import booth_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] p,
  input  logic              p_valid,
  output logic              p_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_nxt;

  booth_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc_i(acc_q),
    .p_i  (p),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  assign cnt_nxt = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          len_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (p_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_nxt;
          if (cnt_nxt == len_q)
            state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign p_ready   = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/booth_acc.md
Name: booth_acc

Overview:
- Downstream consumer of the combinational 8x8 Booth multiplier (16-bit signed product `p`).
- Accumulates a programmed number of products into a wide signed accumulator, i.e. a dot-product engine.
- Presents the sum on a valid/ready output port.
- Sits between the multiplier's product output and the result sink (register bank or next datapath stage).

Parameters:
- ACC_W, 24, accumulator/result width in bits (must be >= 16).
- CNT_W, 8, width of the length field and internal product counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new accumulation; sampled only in IDLE.
- len  input  CNT_W  number of products to accumulate; sampled with start.
- p  input  16  signed two's-complement product from the Booth multiplier.
- p_valid  input  1  product on p is valid.
- p_ready  output  1  block accepts p this cycle.
- acc_out  output  ACC_W  signed accumulated result.
- out_valid  output  1  acc_out holds a final result.
- out_ready  input  1  sink accepts result.
- busy  output  1  high in ACCUM or DONE.
- ovf  output  1  sticky overflow flag for the current/last accumulation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc_out=0, out_valid=0, p_ready=0, busy=0, ovf=0; counter=0, stored length=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - On start=1 with len!=0: clear acc and ovf, store len, counter=0, go to ACCUM.
  - On start=1 with len==0: clear acc and ovf, go directly to DONE; result 0 with out_valid next cycle.
- ACCUM:
  - p_ready=1, combinational from state only; no dependence on p_valid.
  - A transfer occurs when p_valid & p_ready. On transfer: acc <= acc + sign_extend(p); counter++.
  - When the transfer brings counter to the stored len, go to DONE next edge.
  - Cycles without p_valid hold all state.
- DONE:
  - p_ready=0, out_valid=1, acc_out stable.
  - On out_ready=1: out_valid falls next edge, go to IDLE. acc_out keeps its value until the next start.
- Latency: out_valid rises on the edge after the final accepted product. Back-to-back products are accepted one per cycle.
- start outside IDLE is ignored, including a start in DONE coinciding with out_ready. The next start is honoured only once back in IDLE, so there is a minimum of one IDLE cycle between jobs.
- len is ignored except when sampled on an accepted start.
- Arithmetic:
  - p is sign-extended to ACC_W+1 bits and the add is done at ACC_W+1 bits.
  - Signed overflow: operand signs equal and the ACC_W-bit result sign differs.
  - On overflow, ovf sets and stays set until the next accepted start.
  - Default (no saturation): result wraps modulo 2^ACC_W.
- Counter never wraps: the maximum len, 2^CNT_W-1, terminates at exactly that count.
- Reset asserted mid-operation: immediate return to reset values; any partial sum is discarded.
- acc_out is driven directly from the accumulator register; there is no combinational path from inputs to outputs except p_ready from state.

Optional Feature:
- BOOTH_ACC_SAT_EN defined: on overflow, acc saturates to the signed max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)) according to the operand sign. ovf still sets, and later adds continue from the saturated value.
- Undefined: modular wrap, as specified above.

Decomposition:
- Shared package booth_pkg: PROD_W=16 constant, OP_W=8 constant, and the state enum (IDLE, ACCUM, DONE).
- One natural sub-module: booth_acc_add, purely combinational. Function: sign-extend, add, overflow detect, optional saturation under BOOTH_ACC_SAT_EN.
- booth_acc holds the FSM, counter and registers.

Test Plan:
- Reset then len=5, products 30,75,80,50,1000 with p_valid held high: p_ready high 5 cycles; out_valid on the edge after the 5th transfer; acc_out=1235; ovf=0.
- Signed mix, len=3, p=-100,+40,-1: acc_out=-61 (0xFFFFC3 for ACC_W=24). With out_ready held low for 4 cycles: out_valid and acc_out stay stable; clears one edge after out_ready=1.
- len=0 start: no products accepted (p_ready never 1); out_valid next cycle with acc_out=0.
- Gapped p_valid (1,0,0,1,0,1) with len=3, p=7 each: only 3 transfers counted; acc_out=21. start pulses during ACCUM are ignored.
- Overflow, ACC_W=16, len=2, p=32767 twice:
  - Default: acc_out=0xFFFE, ovf=1.
  - BOOTH_ACC_SAT_EN: acc_out=0x7FFF, ovf=1.
  - Next start clears ovf.
- rst_n low for one cycle mid-ACCUM after 2 of 4 products: all outputs return to reset values immediately. A new start with len=1, p=9 gives acc_out=9.
